qpsk_frame_assembler: RTL and testbench
=======================================

Name: qpsk_frame_assembler

Overview:
Receive-side counterpart of the transmit symbol slicer. It collects the 2-bit hard-decision symbols from qpsk_demodulator into one 28-bit interleaved frame and hands that frame to deinterleaver with a valid/ack handshake. It compensates the fixed modulator→channel→demodulator pipeline latency. Sits between qpsk_demodulator and deinterleaver in top.

Parameters:
SYM_W, 2, bits per QPSK symbol
N_SYM, 14, symbols per frame
FRAME_W, 28, frame width (= SYM_W*N_SYM)
LAT, 2, cycles from a symbol entering qpsk_modulator to its appearance on sym_i; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse; high in the cycle symbol 0 is presented to the modulator
sym_i  in  SYM_W  demodulated symbol
frame_o  out  FRAME_W  assembled frame; symbol k at bits [2k+1:2k]
frame_valid  out  1  frame_o holds a complete frame
frame_ack  in  1  consumer accepts frame; sampled only while frame_valid=1
busy  out  1  high in ALIGN or COLLECT
overrun  out  1  sticky: start arrived while not able to accept it

Behaviour:
- Reset (async): state=IDLE, frame_o=0, shadow=0, frame_valid=0, overrun=0, idx=0, dly=0; busy=0.
- All outputs registered except busy (decoded from state).
- States: IDLE, ALIGN, COLLECT, HOLD.
- IDLE: start=1 at edge t0 → ALIGN, dly<=LAT.
- ALIGN: at each edge, if dly==1 → shadow[1:0]<=sym_i, idx<=1, →COLLECT; else dly<=dly-1. Symbol 0 is therefore sampled at edge t0+LAT.
- COLLECT: at each edge, shadow[2*idx+1:2*idx]<=sym_i, idx<=idx+1. On the edge with idx==N_SYM-1, the edge is t0+LAT+13: frame_o<={sym_i, shadow[25:0]}, frame_valid<=1, →HOLD.
- frame_valid first visible in cycle t0+LAT+14. Latency from start to valid = LAT+14 cycles.
- HOLD: frame_o and frame_valid stable until an edge with frame_ack=1. At that edge frame_valid<=0 and the state goes →IDLE. If start=1 at the same edge, the state goes →ALIGN with dly<=LAT, so back-to-back frames are accepted.
- frame_ack while frame_valid=0: ignored.
- start while in ALIGN or COLLECT, or in HOLD without a same-edge ack: ignored, overrun<=1. The current frame continues unaffected.
- overrun clears only on rst.
- frame_o is updated only at frame completion. The previous frame remains on frame_o through IDLE/ALIGN/COLLECT of the next frame.
- Reset mid-frame: immediate return to the reset values. The partial frame is discarded.
- Arithmetic: idx is 4 bits and never exceeds N_SYM-1. dly is 4 bits. No wrap-around in either counter.

Decomposition:
- Shared package: state encoding (IDLE=0, ALIGN=1, COLLECT=2, HOLD=3), SYM_W/N_SYM/FRAME_W constants shared with the transmit slicer and deinterleaver.
- Single module. No sub-module: the shift/index logic is too small to split.

Test Plan:
- Nominal, LAT=2: start at cycle 10. Drive sym_i=k mod 4 for symbol k in cycles 12..25 → frame_valid rises in cycle 26 with frame_o=28'h4E4E4E4. Hold frame_ack=0 for 5 cycles → frame_o and frame_valid remain stable. Ack at cycle 31 → frame_valid=0 in cycle 32.
- Latency sweep, LAT=1 and LAT=15: same symbol pattern, offset by LAT → frame_o=28'h4E4E4E4, frame_valid at start+LAT+14 exactly.
- Back-to-back: frame_ack and start high on the same edge in HOLD. Second frame all symbols 2'b11 → second frame_o=28'hFFFFFFF. overrun stays 0. No cycle is lost.
- Overrun: start pulse during COLLECT (symbol 5) → overrun=1. The frame still completes correctly (28'h4E4E4E4). overrun persists after ack.
- Reset mid-COLLECT at symbol 7 → frame_valid=0, busy=0, frame_o=0, overrun=0 immediately (asynchronous). A subsequent full frame assembles correctly.
- Loopback in top: source 16'b0001_0100_0111_1100 through the full chain with noise disabled → deinterleaver output equals the interleaver input, and hamming_dec=16'h147C.

Source files
------------

// File: rtl/qpsk_frame_assembler_pkg.sv
// qpsk_frame_assembler_pkg
//   Shared constants and state encoding for the receive-side frame assembler.
//   SYM_W, N_SYM and FRAME_W are common to the transmit slicer and the
//   deinterleaver, so all three agree on the frame layout.
package qpsk_frame_assembler_pkg;

  localparam int SYM_W   = 2;
  localparam int N_SYM   = 14;
  localparam int FRAME_W = SYM_W * N_SYM;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/qpsk_frame_assembler_if.sv
// qpsk_frame_assembler_if
//   Bundles the symbol input, frame handshake and status signals of the
//   frame assembler.
//   slave  : the assembler side (consumes start/sym_i/frame_ack)
//   master : the surrounding logic (drives start/sym_i/frame_ack)
//   Signals: start, sym_i[SYM_W], frame_o[FRAME_W], frame_valid, frame_ack,
//            busy, overrun
import qpsk_frame_assembler_pkg::*;

interface qpsk_frame_assembler_if;
  logic               start;
  logic [SYM_W-1:0]   sym_i;
  logic [FRAME_W-1:0] frame_o;
  logic               frame_valid;
  logic               frame_ack;
  logic               busy;
  logic               overrun;

  modport slave (
    input  start, sym_i, frame_ack,
    output frame_o, frame_valid, busy, overrun
  );

  modport master (
    output start, sym_i, frame_ack,
    input  frame_o, frame_valid, busy, overrun
  );
endinterface

// File: rtl/qpsk_frame_assembler.sv
// qpsk_frame_assembler
//   Collects N_SYM demodulated 2-bit symbols into one FRAME_W-bit frame and
//   presents it to the deinterleaver with a valid/ack handshake. The start
//   pulse marks symbol 0 entering the modulator; LAT (1..15) is the fixed
//   modulator->channel->demodulator delay, so symbol 0 is sampled LAT edges
//   after the start edge.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - qpsk_frame_assembler_if.slave:
//          start, sym_i in; frame_o (symbol k at [2k+1:2k]), frame_valid out;
//          frame_ack in; busy (ALIGN/COLLECT) out; overrun (sticky) out
module qpsk_frame_assembler
  import qpsk_frame_assembler_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  qpsk_frame_assembler_if.slave  bus
);

  state_t             state;
  logic [3:0]         idx;
  logic [3:0]         dly;
  logic [FRAME_W-1:0] shadow;

  assign bus.busy = (state == ALIGN) || (state == COLLECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= 4'd0;
      dly             <= 4'd0;
      shadow          <= '0;
      bus.frame_o     <= '0;
      bus.frame_valid <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= ALIGN;
            dly   <= LAT[3:0];
          end
        end

        // Count off the channel latency; symbol 0 lands on the edge where
        // dly reaches 1.
        ALIGN: begin
          if (bus.start) bus.overrun <= 1'b1;
          if (dly == 4'd1) begin
            shadow[SYM_W-1:0] <= bus.sym_i;
            idx               <= 4'd1;
            state             <= COLLECT;
          end else begin
            dly <= dly - 4'd1;
          end
        end

        // The last symbol goes straight into frame_o alongside the shadow
        // contents, so the frame is published on the same edge it completes.
        COLLECT: begin
          if (bus.start) bus.overrun <= 1'b1;
          shadow[{idx, 1'b0} +: SYM_W] <= bus.sym_i;
          if (idx == 4'(N_SYM - 1)) begin
            bus.frame_o     <= {bus.sym_i, shadow[FRAME_W-SYM_W-1:0]};
            bus.frame_valid <= 1'b1;
            idx             <= 4'd0;
            state           <= HOLD;
          end else begin
            idx <= idx + 4'd1;
          end
        end

        // A start coinciding with the ack is a legal back-to-back frame.
        HOLD: begin
          if (bus.frame_ack) begin
            bus.frame_valid <= 1'b0;
            if (bus.start) begin
              state <= ALIGN;
              dly   <= LAT[3:0];
            end else begin
              state <= IDLE;
            end
          end else if (bus.start) begin
            bus.overrun <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_frame_assembler.sv
// tb_qpsk_frame_assembler
//   Directed bench for qpsk_frame_assembler with three instances (LAT=1, 2,
//   15) sharing clk/rst. Inputs are driven on the falling edge and outputs
//   are sampled there, away from the rising active edge.
module tb_qpsk_frame_assembler;
  import qpsk_frame_assembler_pkg::*;

  localparam logic [27:0] PAT_MOD4 = 28'h4E4E4E4;
  localparam logic [27:0] PAT_ONES = 28'hFFFFFFF;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  qpsk_frame_assembler_if if1 ();
  qpsk_frame_assembler_if if2 ();
  qpsk_frame_assembler_if if15 ();

  qpsk_frame_assembler #(.LAT(1))  u1  (.clk(clk), .rst(rst), .bus(if1));
  qpsk_frame_assembler #(.LAT(2))  u2  (.clk(clk), .rst(rst), .bus(if2));
  qpsk_frame_assembler #(.LAT(15)) u15 (.clk(clk), .rst(rst), .bus(if15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      1:       if1.start = v;
      2:       if2.start = v;
      default: if15.start = v;
    endcase
  endtask

  task automatic set_ack(input int w, input logic v);
    case (w)
      1:       if1.frame_ack = v;
      2:       if2.frame_ack = v;
      default: if15.frame_ack = v;
    endcase
  endtask

  task automatic set_sym(input int w, input logic [1:0] v);
    case (w)
      1:       if1.sym_i = v;
      2:       if2.sym_i = v;
      default: if15.sym_i = v;
    endcase
  endtask

  function automatic logic [27:0] get_frame(input int w);
    case (w)
      1:       return if1.frame_o;
      2:       return if2.frame_o;
      default: return if15.frame_o;
    endcase
  endfunction

  function automatic logic [27:0] get_valid(input int w);
    case (w)
      1:       return {27'd0, if1.frame_valid};
      2:       return {27'd0, if2.frame_valid};
      default: return {27'd0, if15.frame_valid};
    endcase
  endfunction

  function automatic logic [27:0] get_busy(input int w);
    case (w)
      1:       return {27'd0, if1.busy};
      2:       return {27'd0, if2.busy};
      default: return {27'd0, if15.busy};
    endcase
  endfunction

  function automatic logic [27:0] get_ovr(input int w);
    case (w)
      1:       return {27'd0, if1.overrun};
      2:       return {27'd0, if2.overrun};
      default: return {27'd0, if15.overrun};
    endcase
  endfunction

  // Start pulse sampled at edge t0; returns at the falling edge after t0.
  task automatic send_start(input int w);
    @(negedge clk);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    check("busy_after_start", get_busy(w), 28'd1);
  endtask

  // Called at the falling edge after t0. Symbol k is presented so that it is
  // sampled at edge t0+lat+k. pulse_at>=0 adds a stray start with symbol k.
  task automatic feed(input int w, input int lat, input int mode,
                      input int pulse_at, input int nsym);
    repeat (lat - 1) @(negedge clk);
    for (int k = 0; k < nsym; k++) begin
      set_sym(w, (mode == 0) ? 2'(k % 4) : 2'b11);
      set_start(w, k == pulse_at);
      @(negedge clk);
      set_start(w, 1'b0);
      if (nsym == N_SYM && k == N_SYM - 2)
        check("valid_not_early", get_valid(w), 28'd0);
    end
  endtask

  task automatic do_ack(input int w);
    set_ack(w, 1'b1);
    @(negedge clk);
    set_ack(w, 1'b0);
    check("valid_drop_after_ack", get_valid(w), 28'd0);
  endtask

  initial begin
    rst = 1'b1;
    if1.start = 0;  if1.sym_i = 0;  if1.frame_ack = 0;
    if2.start = 0;  if2.sym_i = 0;  if2.frame_ack = 0;
    if15.start = 0; if15.sym_i = 0; if15.frame_ack = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid",   get_valid(2), 28'd0);
    check("rst_frame",   get_frame(2), 28'd0);
    check("rst_busy",    get_busy(2),  28'd0);
    check("rst_overrun", get_ovr(2),   28'd0);
    check("rst_frame15", get_frame(15), 28'd0);
    rst = 1'b0;

    // Ack with no frame pending is ignored
    @(negedge clk);
    set_ack(2, 1'b1);
    @(negedge clk);
    set_ack(2, 1'b0);
    check("idle_ack_valid", get_valid(2), 28'd0);
    check("idle_ack_busy",  get_busy(2),  28'd0);

    // Nominal LAT=2 frame, held for 5 cycles without ack
    send_start(2);
    feed(2, 2, 0, -1, N_SYM);
    check("nom_valid", get_valid(2), 28'd1);
    check("nom_frame", get_frame(2), PAT_MOD4);
    check("nom_busy",  get_busy(2),  28'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", get_valid(2), 28'd1);
      check("hold_frame", get_frame(2), PAT_MOD4);
    end
    do_ack(2);
    check("nom_frame_kept", get_frame(2), PAT_MOD4);
    check("nom_overrun",    get_ovr(2),   28'd0);

    // LAT=1, plus a start in HOLD without ack sets overrun
    send_start(1);
    feed(1, 1, 0, -1, N_SYM);
    check("lat1_valid", get_valid(1), 28'd1);
    check("lat1_frame", get_frame(1), PAT_MOD4);
    set_start(1, 1'b1);
    @(negedge clk);
    set_start(1, 1'b0);
    check("hold_start_overrun", get_ovr(1),   28'd1);
    check("hold_start_valid",   get_valid(1), 28'd1);
    check("hold_start_busy",    get_busy(1),  28'd0);
    do_ack(1);

    // LAT=15
    send_start(15);
    feed(15, 15, 0, -1, N_SYM);
    check("lat15_valid", get_valid(15), 28'd1);
    check("lat15_frame", get_frame(15), PAT_MOD4);
    check("lat15_overrun", get_ovr(15), 28'd0);
    do_ack(15);

    // Back-to-back: ack and start on the same edge
    send_start(2);
    feed(2, 2, 0, -1, N_SYM);
    check("b2b_first_frame", get_frame(2), PAT_MOD4);
    set_ack(2, 1'b1);
    set_start(2, 1'b1);
    @(negedge clk);
    set_ack(2, 1'b0);
    set_start(2, 1'b0);
    check("b2b_valid_low", get_valid(2), 28'd0);
    check("b2b_busy",      get_busy(2),  28'd1);
    check("b2b_prev_kept", get_frame(2), PAT_MOD4);
    feed(2, 2, 1, -1, N_SYM);
    check("b2b_valid",   get_valid(2), 28'd1);
    check("b2b_frame",   get_frame(2), PAT_ONES);
    check("b2b_overrun", get_ovr(2),   28'd0);
    do_ack(2);

    // Overrun: stray start during symbol 5
    send_start(2);
    feed(2, 2, 0, 5, N_SYM);
    check("ovr_set",   get_ovr(2),   28'd1);
    check("ovr_valid", get_valid(2), 28'd1);
    check("ovr_frame", get_frame(2), PAT_MOD4);
    do_ack(2);
    check("ovr_sticky", get_ovr(2), 28'd1);

    // Asynchronous reset mid-COLLECT after symbol 7
    send_start(2);
    feed(2, 2, 1, -1, 8);
    check("pre_rst_busy", get_busy(2), 28'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid",   get_valid(2), 28'd0);
    check("arst_busy",    get_busy(2),  28'd0);
    check("arst_frame",   get_frame(2), 28'd0);
    check("arst_overrun", get_ovr(2),   28'd0);
    @(negedge clk);
    rst = 1'b0;
    send_start(2);
    feed(2, 2, 0, -1, N_SYM);
    check("post_rst_valid", get_valid(2), 28'd1);
    check("post_rst_frame", get_frame(2), PAT_MOD4);
    do_ack(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
